// File: rtl/apu_pkg.sv
// Shared tables and register indices for the APU channel cores.
// Length and duty tables follow the standard NES values.
package apu_pkg;

  typedef enum logic [1:0] {
    REG_CTRL      = 2'd0,
    REG_SWEEP     = 2'd1,
    REG_PERIOD_LO = 2'd2,
    REG_PERIOD_HI = 2'd3
  } reg_idx_e;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Row MSB is step 0.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] row;
    row = DUTY_TABLE[duty];
    return row[3'd7 - step];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: decays 15..0 at a rate set by vol, optional loop.
// Shared by the pulse and noise channels.
module apu_envelope (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic       qframe,
  input  logic       loop,
  input  logic       const_vol,
  input  logic [3:0] vol,
  output logic [3:0] volume
);

  logic       start_flag;
  logic [3:0] divider;
  logic [3:0] decay;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      start_flag <= 1'b0;
      divider    <= 4'd0;
      decay      <= 4'd0;
    end else begin
      if (qframe) begin
        if (start_flag) begin
          start_flag <= 1'b0;
          decay      <= 4'd15;
          divider    <= vol;
        end else if (divider == 4'd0) begin
          divider <= vol;
          if (decay != 4'd0)
            decay <= decay - 4'd1;
          else if (loop)
            decay <= 4'd15;
        end else begin
          divider <= divider - 4'd1;
        end
      end
      // A new start request must survive a coincident quarter-frame.
      if (start)
        start_flag <= 1'b1;
    end
  end

  assign volume = const_vol ? vol : decay;

endmodule

// File: rtl/apu_pulse_gen.sv
// Pulse channel core: register file, duty sequencer, length counter, sweep
// and envelope; drives the companion timer's period and reload strobe.
module apu_pulse_gen
  import apu_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        timer_tick,
  input  logic        qframe,
  input  logic        hframe,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_data,
  input  logic        enable,
  output logic [10:0] timer_load,
  output logic        timer_reload,
  output logic        active,
  output logic [3:0]  out
);

  logic [1:0]  duty;
  logic        halt_loop;
  logic        const_vol;
  logic [3:0]  vol;
  logic        sweep_en;
  logic [2:0]  sweep_per;
  logic        negate;
  logic [2:0]  shift;
  logic [10:0] period;
  logic [7:0]  len;
  logic [2:0]  step;
  logic [2:0]  sweep_div;
  logic        sweep_reload;

  logic        wr_ctrl, wr_sweep, wr_lo, wr_hi;
  logic [10:0] delta;
  logic [11:0] target;
  logic        mute;
  logic        sweep_upd;
  logic        wave;
  logic [3:0]  env_vol;

  assign wr_ctrl  = reg_we && (reg_addr == REG_CTRL);
  assign wr_sweep = reg_we && (reg_addr == REG_SWEEP);
  assign wr_lo    = reg_we && (reg_addr == REG_PERIOD_LO);
  assign wr_hi    = reg_we && (reg_addr == REG_PERIOD_HI);

  // Pulse 1 negates in ones'-complement, so it lands one lower than pulse 2.
  always_comb begin
    delta = period >> shift;
    if (negate)
      target = {1'b0, period} - {1'b0, delta} - ((CHANNEL == 0) ? 12'd1 : 12'd0);
    else
      target = {1'b0, period} + {1'b0, delta};
  end

  assign mute      = (period < 11'd8) || (!negate && target[11]);
  assign sweep_upd = hframe && (sweep_div == 3'd0) && sweep_en && (shift != 3'd0) && !mute;
  assign wave      = duty_bit(duty, step);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      duty      <= 2'd0;
      halt_loop <= 1'b0;
      const_vol <= 1'b0;
      vol       <= 4'd0;
      sweep_en  <= 1'b0;
      sweep_per <= 3'd0;
      negate    <= 1'b0;
      shift     <= 3'd0;
    end else begin
      if (wr_ctrl)
        {duty, halt_loop, const_vol, vol} <= reg_data;
      if (wr_sweep)
        {sweep_en, sweep_per, negate, shift} <= reg_data;
    end
  end

  // Register writes to the period take precedence over a sweep adjustment.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      period       <= 11'd0;
      sweep_div    <= 3'd0;
      sweep_reload <= 1'b0;
    end else begin
      if (wr_lo || wr_hi) begin
        if (wr_lo)
          period[7:0] <= reg_data;
        if (wr_hi)
          period[10:8] <= reg_data[2:0];
      end else if (sweep_upd) begin
        period <= target[10:0];
      end
      if (hframe) begin
        if (sweep_div == 3'd0 || sweep_reload) begin
          sweep_div    <= sweep_per;
          sweep_reload <= 1'b0;
        end else begin
          sweep_div <= sweep_div - 3'd1;
        end
      end
      if (wr_sweep)
        sweep_reload <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      step         <= 3'd0;
      len          <= 8'd0;
      timer_reload <= 1'b0;
      out          <= 4'd0;
    end else begin
      timer_reload <= wr_hi;
      if (wr_hi)
        step <= 3'd0;
      else if (timer_tick)
        step <= step + 3'd1;
      if (!enable)
        len <= 8'd0;
      else if (wr_hi)
        len <= LEN_TABLE[reg_data[7:3]];
      else if (hframe && !halt_loop && len != 8'd0)
        len <= len - 8'd1;
      out <= (mute || len == 8'd0 || !wave) ? 4'd0 : env_vol;
    end
  end

  apu_envelope u_envelope (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (wr_hi),
    .qframe    (qframe),
    .loop      (halt_loop),
    .const_vol (const_vol),
    .vol       (vol),
    .volume    (env_vol)
  );

  assign timer_load = period;
  assign active     = (len != 8'd0);

endmodule

// File: doc/apu_pulse_gen.md
Name: apu_pulse_gen

Overview:
- Pulse-channel core for the APU. It is the consumer end of the channel timer interface: it supplies the period (`timer_load`) and a restart strobe (`timer_reload`) to the channel timer, and it advances its duty sequencer on each timer expiry (`timer_tick`).
- It also contains the envelope, length counter and sweep units, and produces the 4-bit channel volume for the mixer.
- Two instances exist: pulse 1 and pulse 2.

Parameters:
- `CHANNEL`, default 0. 0 selects pulse 1, where sweep negate is ones'-complement (subtracts delta+1). 1 selects pulse 2, where negate subtracts delta.

Ports:
- `clk`  in  1  system clock
- `n_reset`  in  1  synchronous active-low reset
- `timer_tick`  in  1  one-cycle enable; companion timer reached zero
- `qframe`  in  1  one-cycle quarter-frame enable from frame counter
- `hframe`  in  1  one-cycle half-frame enable from frame counter
- `reg_we`  in  1  register write strobe
- `reg_addr`  in  2  channel register index 0..3
- `reg_data`  in  8  write data
- `enable`  in  1  channel enable bit from status register
- `timer_load`  out  11  current period, fed to the timer load input
- `timer_reload`  out  1  one-cycle strobe; forces the timer to reload
- `active`  out  1  length counter non-zero
- `out`  out  4  channel volume sample

Behaviour:
- Reset: everything is synchronous on `clk`; `n_reset` low clears all state.
  - All outputs and internal registers go to 0.
  - The envelope start flag and the sweep reload flag are cleared.
- Register map:
  - Reg0: [7:6] duty, [5] halt/loop, [4] constant volume, [3:0] volume/envelope period.
  - Reg1: [7] sweep enable, [6:4] sweep period, [3] negate, [2:0] shift. Any write sets the sweep reload flag.
  - Reg2: `period[7:0]`.
  - Reg3: [7:3] length index, [2:0] `period[10:8]`. A write does all of the following:
    - Sets the envelope start flag.
    - Resets the sequencer step to 0.
    - Pulses `timer_reload` on the next cycle.
    - Loads `len <= LEN_TABLE[index]`, but only if `enable` = 1.
- `timer_load` is the period register, driven directly (no added latency).
- `timer_reload` latency: high for exactly one cycle, the cycle after the Reg3 write.
- Sequencer: 3-bit step.
  - On `timer_tick`: `step <= step + 1`, wrapping 7 to 0.
  - Waveform bit = `DUTY_TABLE[duty][step]`.
  - A Reg3 write in the same cycle as `timer_tick` wins: step becomes 0.
- Envelope (on `qframe`):
  - If the start flag is set: clear the flag, `decay <= 15`, `divider <= vol`.
  - Else if `divider == 0`: `divider <= vol`; then if `decay != 0`, decrement `decay`; else if loop is set, `decay <= 15`.
  - Else: decrement `divider`.
  - Envelope volume = constant flag ? `vol` : `decay`.
- Length counter (8-bit):
  - On `hframe`: if halt = 0 and `len != 0`, decrement `len`.
  - `enable` = 0 clears `len` on the next cycle and blocks loads.
  - A Reg3 load in the same cycle as `hframe` wins over the decrement.
  - `active = (len != 0)`.
- Sweep:
  - `delta = period >> shift`. `target` is 12 bits.
  - Negate = 0: `target = period + delta`.
  - Negate = 1: `target = period - delta - (CHANNEL == 0 ? 1 : 0)`, computed in 12 bits.
  - `mute = (period < 8) | (negate == 0 & target[11])`.
  - On `hframe`: if `divider == 0` and enable and `shift != 0` and !mute, then `period <= target[10:0]`.
  - Also on `hframe`: if `divider == 0` or the reload flag is set, then `divider <= sweep period` and clear the reload flag; else decrement `divider`.
  - A Reg2/Reg3 write in the same cycle as a sweep update wins over the sweep update.
- Output: registered, one-cycle latency from state.
  - `out = 0` if mute, `len == 0`, or the waveform bit is 0.
  - Otherwise `out` = envelope volume.
- Reset mid-operation: state is cleared on the next edge. A pending `timer_reload` is dropped.

Decomposition:
- Package `apu_pkg` holds:
  - `LEN_TABLE` (32 x 8 bit, standard NES values).
  - `DUTY_TABLE` (4 x 8 bit: 01000000, 01100000, 01111000, 10011111, indexed by step, MSB = step 0).
  - Register index constants.
- Sub-module `apu_envelope`:
  - Inputs: start flag, `qframe`, loop, constant flag, `vol`.
  - Output: 4-bit volume.
  - Reused by the noise channel.

Test Plan:
- Reset then idle: `out` = 0, `active` = 0, `timer_load` = 0, `timer_reload` never asserted.
- With `enable` = 1, write Reg0 = 0xBF, Reg2 = 0x20, Reg3 = 0x08, then drive 8 `timer_tick`s.
  - `timer_load` = 0x020.
  - `timer_reload` high exactly one cycle after the Reg3 write.
  - `len` = 254.
  - `out` pattern is 0,15,15,15,15,0,0,0 (50% duty).
- Envelope: Reg0 = 0x02 (vol 2, no constant, no loop), Reg3 write, then `qframe`s.
  - `decay` = 15 after the first `qframe`.
  - Decrements every 3 `qframe`s.
  - Sticks at 0.
  - With loop set (Reg0 = 0x22), decay wraps back to 15.
- Length counter:
  - Index 0x01 gives `len` = 254; 254 `hframe`s bring `active` to 0.
  - Halt set: `len` is frozen.
  - `enable` dropped: `active` = 0 next cycle.
  - A Reg3 write while `enable` = 0 does not load.
- Sweep on pulse 1, period 0x100, shift 1, sweep period 0, one `hframe`:
  - Negate = 1: period becomes 0x07F.
  - Pulse 2 (`CHANNEL` = 1), same setup: period becomes 0x080.
  - Negate = 0 with period 0x600: target 0x900 > 0x7FF, so mute, `out` = 0, and period is unchanged.
- Simultaneous events:
  - Reg3 write with `timer_tick`: step = 0.
  - Reg3 write with `hframe`: `len` = table value, not decremented.
  - Reg2 write with a sweep update: written value wins.
